// File: rtl/ring_state_seq.sv
// ---------------------------------------------------------------------------
// ring_state_seq
//   Registered state sequencer for small control FSMs and phase generators.
//   Two modes are supported:
//     * ring mode: a one-hot rotate register.
//     * Johnson mode: a twisted-ring register.
//   Other features:
//     * The state steps toward the MSB or toward the LSB.
//     * Parallel load takes priority over stepping.
//     * A state that is illegal in the current mode is replaced by the mode's
//       home value on the next enabled step. That step raises err and latches
//       err_sticky.
//     * wrap pulses when an enabled step lands on home.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   en         : advance one step
//   dir        : 0 = toward MSB (left), 1 = toward LSB (right)
//   mode       : 0 = ring (one-hot), 1 = Johnson
//   load       : parallel load of load_val (priority over en)
//   load_val   : value loaded when load = 1
//   clr_err    : clears err_sticky (a new error on the same edge wins)
//   state      : registered current state
//   next_state : combinational value taken on the next enabled step
//   wrap       : registered pulse, enabled step landed on home
//   err        : registered pulse, illegal state was replaced by home
//   err_sticky : sticky illegal-state flag
// ---------------------------------------------------------------------------
module ring_state_seq #(
  parameter int                 WIDTH     = 3,
  parameter logic [WIDTH-1:0]   RING_HOME = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_err,
  output logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state,
  output logic             wrap,
  output logic             err,
  output logic             err_sticky
);

  logic [WIDTH-1:0] r_state;
  logic             r_wrap;
  logic             r_err;
  logic             r_err_sticky;

  logic [WIDTH-1:0] w_home;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_next;
  logic             w_legal;
  logic             w_err_set;

  // Number of set bits; a legal ring state has exactly one.
  function automatic int unsigned f_popcount(input logic [WIDTH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Number of adjacent bit pairs that differ; a Johnson state has at most one.
  function automatic int unsigned f_transitions(input logic [WIDTH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) c++;
    end
    return c;
  endfunction

  assign w_home  = mode ? '0 : RING_HOME;
  assign w_legal = mode ? (f_transitions(r_state) <= 1) : (f_popcount(r_state) == 1);

  always_comb begin
    w_step = r_state;
    case ({mode, dir})
      2'b00:   w_step = {r_state[WIDTH-2:0], r_state[WIDTH-1]};
      2'b01:   w_step = {r_state[0], r_state[WIDTH-1:1]};
      2'b10:   w_step = {r_state[WIDTH-2:0], ~r_state[WIDTH-1]};
      2'b11:   w_step = {~r_state[0], r_state[WIDTH-1:1]};
      default: w_step = r_state;
    endcase
  end

  // An illegal state never propagates: the step target becomes home.
  assign w_next    = w_legal ? w_step : w_home;
  assign w_err_set = !load && en && !w_legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RING_HOME;
      r_wrap       <= 1'b0;
      r_err        <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      if (load) begin
        r_state <= load_val;
        r_wrap  <= 1'b0;
        r_err   <= 1'b0;
      end else if (en) begin
        r_state <= w_next;
        r_wrap  <= w_legal && (w_next == w_home);
        r_err   <= !w_legal;
      end else begin
        r_wrap  <= 1'b0;
        r_err   <= 1'b0;
      end
      // A new error on this edge overrides a simultaneous clear.
      if (w_err_set)    r_err_sticky <= 1'b1;
      else if (clr_err) r_err_sticky <= 1'b0;
    end
  end

  assign state      = r_state;
  assign next_state = w_next;
  assign wrap       = r_wrap;
  assign err        = r_err;
  assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_ring_state_seq.sv
// Bench for ring_state_seq. A WIDTH=3 and a WIDTH=4 instance share all control
// inputs; an arithmetic model tracks both and is compared every negedge, and
// directed literal expectations pin the model to hand-derived sequences.
module tb_ring_state_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0, clr_err = 1'b0;
  logic [2:0] lv3 = '0;
  logic [3:0] lv4 = '0;

  logic [2:0] st3, nx3;
  logic [3:0] st4, nx4;
  logic wr3, er3, sk3, wr4, er4, sk4;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  ring_state_seq #(.WIDTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv3), .clr_err(clr_err), .state(st3), .next_state(nx3),
    .wrap(wr3), .err(er3), .err_sticky(sk3)
  );

  ring_state_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .mode(mode), .load(load),
    .load_val(lv4), .clr_err(clr_err), .state(st4), .next_state(nx4),
    .wrap(wr4), .err(er4), .err_sticky(sk4)
  );

  // ---------------- behavioural model ----------------
  logic [7:0] ms [2];
  logic       mwrap [2];
  logic       merr [2];
  logic       msticky [2];

  function automatic int wid(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic logic [7:0] mask(input int w);
    return 8'((9'd1 << w) - 9'd1);
  endfunction

  function automatic bit m_legal(input int w, input logic md, input logic [7:0] s);
    if (!md) return $countones(s) == 1;
    return $countones((s ^ (s >> 1)) & (mask(w) >> 1)) <= 1;
  endfunction

  function automatic logic [7:0] m_home(input logic md);
    return md ? 8'd0 : 8'd1;
  endfunction

  function automatic logic [7:0] m_next(input int w, input logic md, input logic dr,
                                         input logic [7:0] s);
    logic [7:0] b;
    b = '0;
    if (!m_legal(w, md, s)) return m_home(md);
    if (!md) begin
      if (!dr) return ((s << 1) | (s >> (w - 1))) & mask(w);
      return ((s >> 1) | (s << (w - 1))) & mask(w);
    end
    if (!dr) begin
      b[0] = ~s[w-1];
      return ((s << 1) & mask(w)) | b;
    end
    b[w-1] = ~s[0];
    return (s >> 1) | b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        ms[k] <= 8'd1; mwrap[k] <= 1'b0; merr[k] <= 1'b0; msticky[k] <= 1'b0;
      end else begin
        if (load) begin
          ms[k] <= ((k == 0) ? {5'd0, lv3} : {4'd0, lv4});
          mwrap[k] <= 1'b0; merr[k] <= 1'b0;
        end else if (en) begin
          ms[k] <= m_next(wid(k), mode, dir, ms[k]);
          mwrap[k] <= m_legal(wid(k), mode, ms[k]) &&
                      (m_next(wid(k), mode, dir, ms[k]) == m_home(mode));
          merr[k] <= !m_legal(wid(k), mode, ms[k]);
        end else begin
          mwrap[k] <= 1'b0; merr[k] <= 1'b0;
        end
        if (!load && en && !m_legal(wid(k), mode, ms[k])) msticky[k] <= 1'b1;
        else if (clr_err) msticky[k] <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state3", {5'd0, st3}, ms[0]);
      chk("next3",  {5'd0, nx3}, m_next(3, mode, dir, ms[0]));
      chk("wrap3",  {7'd0, wr3}, {7'd0, mwrap[0]});
      chk("err3",   {7'd0, er3}, {7'd0, merr[0]});
      chk("stk3",   {7'd0, sk3}, {7'd0, msticky[0]});
      chk("state4", {4'd0, st4}, ms[1]);
      chk("next4",  {4'd0, nx4}, m_next(4, mode, dir, ms[1]));
      chk("wrap4",  {7'd0, wr4}, {7'd0, mwrap[1]});
      chk("err4",   {7'd0, er4}, {7'd0, merr[1]});
      chk("stk4",   {7'd0, sk4}, {7'd0, msticky[1]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] jexp [8];

  initial begin
    jexp = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

    // Reset asserted mid-cycle takes effect immediately.
    #1 rst_n = 1'b0;
    #1;
    chk("lit_rst_state", {5'd0, st3}, 8'h01);
    chk("lit_rst_wrap",  {7'd0, wr3}, 8'h00);
    chk("lit_rst_err",   {7'd0, er3}, 8'h00);
    chk("lit_rst_stk",   {7'd0, sk3}, 8'h00);
    chk_on = 1'b1;
    cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    chk("lit_hold", {5'd0, st3}, 8'h01);

    // Ring, left.
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    cyc();
    chk("lit_rl1", {5'd0, st3}, 8'h02);
    chk("lit_rl1_wrap", {7'd0, wr3}, 8'h00);
    chk("lit_rl1_next", {5'd0, nx3}, 8'h04);
    cyc();
    chk("lit_rl2", {5'd0, st3}, 8'h04);
    cyc();
    chk("lit_rl3", {5'd0, st3}, 8'h01);
    chk("lit_rl3_wrap", {7'd0, wr3}, 8'h01);

    // Ring, right, then direction flip at 010.
    dir = 1'b1;
    cyc();
    chk("lit_rr1", {5'd0, st3}, 8'h04);
    chk("lit_rr1_wrap", {7'd0, wr3}, 8'h00);
    cyc();
    chk("lit_rr2", {5'd0, st3}, 8'h02);
    dir = 1'b0;
    #1;
    chk("lit_flip_next", {5'd0, nx3}, 8'h04);
    cyc();
    chk("lit_flip", {5'd0, st3}, 8'h04);

    // Johnson, WIDTH=4, from 0000.
    mode = 1'b1; load = 1'b1; lv3 = 3'b000; lv4 = 4'b0000;
    cyc();
    chk("lit_jload", {4'd0, st4}, 8'h00);
    load = 1'b0; en = 1'b1; dir = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("lit_j_state", {4'd0, st4}, {4'd0, jexp[i]});
      chk("lit_j_wrap", {7'd0, wr4}, (i == 7) ? 8'h01 : 8'h00);
    end

    // Illegal recovery and sticky flag.
    mode = 1'b0; en = 1'b0; load = 1'b1; lv3 = 3'b110; lv4 = 4'b0110;
    cyc();
    chk("lit_ill_load", {5'd0, st3}, 8'h06);
    load = 1'b0; en = 1'b1;
    cyc();
    chk("lit_ill_rec", {5'd0, st3}, 8'h01);
    chk("lit_ill_err", {7'd0, er3}, 8'h01);
    chk("lit_ill_stk", {7'd0, sk3}, 8'h01);
    en = 1'b0;
    cyc();
    chk("lit_err_pulse", {7'd0, er3}, 8'h00);
    chk("lit_stk_keep", {7'd0, sk3}, 8'h01);
    clr_err = 1'b1;
    cyc();
    chk("lit_stk_clr", {7'd0, sk3}, 8'h00);
    clr_err = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0; en = 1'b1;
    cyc();
    chk("lit_stk_set2", {7'd0, sk3}, 8'h01);
    en = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0; en = 1'b1; clr_err = 1'b1;
    cyc();
    chk("lit_stk_win", {7'd0, sk3}, 8'h01);
    chk("lit_stk_win_err", {7'd0, er3}, 8'h01);
    clr_err = 1'b0; en = 1'b0;

    // Load has priority over en.
    load = 1'b1; en = 1'b1; lv3 = 3'b100; lv4 = 4'b0100;
    cyc();
    chk("lit_prio", {5'd0, st3}, 8'h04);
    chk("lit_prio_wrap", {7'd0, wr3}, 8'h00);
    chk("lit_prio_err", {7'd0, er3}, 8'h00);
    load = 1'b0;

    // Asynchronous reset during a Johnson run.
    mode = 1'b1; en = 1'b1; dir = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("lit_arst3", {5'd0, st3}, 8'h01);
    chk("lit_arst4", {4'd0, st4}, 8'h01);
    chk("lit_arst_stk3", {7'd0, sk3}, 8'h00);
    chk("lit_arst_wrap4", {7'd0, wr4}, 8'h00);
    chk("lit_arst_err4", {7'd0, er4}, 8'h00);
    cyc();
    rst_n = 1'b1; en = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
